// File: rtl/testbench_ls_nios_cpu_cpu_oci_mem_arbiter_if.sv
// testbench_ls_nios_cpu_cpu_oci_mem_arbiter_if: CPU Avalon debug-memory port into the OCI RAM arbiter
interface testbench_ls_nios_cpu_cpu_oci_mem_arbiter_if #(parameter int ADDR_W = 8);
  logic [ADDR_W-1:0] cpu_address;
  logic              cpu_read;
  logic              cpu_write;
  logic [31:0]       cpu_writedata;
  logic [3:0]        cpu_byteenable;
  logic [31:0]       cpu_readdata;
  logic              cpu_waitrequest;
  modport master (output cpu_address, cpu_read, cpu_write, cpu_writedata, cpu_byteenable,
                  input cpu_readdata, cpu_waitrequest);
  modport slave (input cpu_address, cpu_read, cpu_write, cpu_writedata, cpu_byteenable,
                 output cpu_readdata, cpu_waitrequest);
endinterface

// File: rtl/testbench_ls_nios_cpu_cpu_oci_mem_arbiter.sv
// testbench_ls_nios_cpu_cpu_oci_mem_arbiter: round-robin share of the OCI debug RAM between JTAG and CPU
module testbench_ls_nios_cpu_cpu_oci_mem_arbiter #(parameter int ADDR_W = 8) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  output logic [31:0]       MonDReg,
  output logic              jtag_busy,
  output logic              jtag_overrun,
  testbench_ls_nios_cpu_cpu_oci_mem_arbiter_if.slave cpu,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [3:0]        ram_be,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);
  typedef enum logic [1:0] {IDLE, JRD, CRD} state_t;
  state_t state, state_nx;
  logic [ADDR_W-1:0] jtag_addr;
  logic [31:0] jtag_wdata;
  logic pend_rd, pend_wr, last_jtag;
  logic cpu_req, in_idle, jtag_gnt, cpu_gnt, jtag_wr_gnt, cpu_wr_gnt, jtag_done;
  logic any_strb, multi_strb;
  logic unused_jdo;
  assign unused_jdo = ^{jdo[37:36], jdo[2:0]};
  assign jtag_busy = pend_rd | pend_wr;
  assign any_strb = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
  assign multi_strb = (take_action_ocimem_a & take_no_action_ocimem_a) |
                      (take_action_ocimem_a & take_action_ocimem_b) |
                      (take_no_action_ocimem_a & take_action_ocimem_b);
  // Grants are suppressed while reset is held so nothing reaches the RAM write port.
  always_comb begin
    cpu_req = cpu.cpu_read | cpu.cpu_write;
    in_idle = reset_n && state == IDLE;
    jtag_gnt = in_idle && jtag_busy && (!cpu_req || !last_jtag);
    cpu_gnt = in_idle && cpu_req && !jtag_gnt;
    jtag_wr_gnt = jtag_gnt && pend_wr;
    cpu_wr_gnt = cpu_gnt && cpu.cpu_write;
    jtag_done = jtag_wr_gnt || state == JRD;
    state_nx = (jtag_gnt && pend_rd) ? JRD : (cpu_gnt && cpu.cpu_read) ? CRD : IDLE;
    ram_we = jtag_wr_gnt || cpu_wr_gnt;
    ram_be = jtag_wr_gnt ? 4'hF : cpu_wr_gnt ? cpu.cpu_byteenable : 4'h0;
    ram_addr = jtag_gnt ? jtag_addr : cpu_gnt ? cpu.cpu_address : '0;
    ram_wdata = jtag_wr_gnt ? jtag_wdata : cpu_wr_gnt ? cpu.cpu_writedata : 32'h0;
    cpu.cpu_readdata = state == CRD ? ram_rdata : 32'h0;
    cpu.cpu_waitrequest = cpu_req && !(cpu_wr_gnt || state == CRD);
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      MonDReg <= 32'h0;
      jtag_overrun <= 1'b0;
      jtag_addr <= '0;
      jtag_wdata <= 32'h0;
      pend_rd <= 1'b0;
      pend_wr <= 1'b0;
      last_jtag <= 1'b0;
    end else begin
      state <= state_nx;
      if (jtag_gnt || cpu_gnt) last_jtag <= jtag_gnt;
      if (state == JRD) MonDReg <= ram_rdata;
      if ((any_strb && jtag_busy) || multi_strb) jtag_overrun <= 1'b1;
      if (jtag_done) begin
        pend_rd <= 1'b0;
        pend_wr <= 1'b0;
        jtag_addr <= jtag_addr + 1'b1;
      end else if (!jtag_busy) begin
        if (take_action_ocimem_a) begin
          jtag_addr <= jdo[26 +: ADDR_W];
          pend_rd <= jdo[35];
        end else if (take_no_action_ocimem_a) pend_rd <= 1'b1;
        else if (take_action_ocimem_b) begin
          pend_wr <= 1'b1;
          jtag_wdata <= jdo[34:3];
        end
      end
    end
  end
endmodule

// File: tb/tb_testbench_ls_nios_cpu_cpu_oci_mem_arbiter.sv
// tb_testbench_ls_nios_cpu_cpu_oci_mem_arbiter: directed checks of JTAG/CPU sharing of the OCI RAM
module tb_testbench_ls_nios_cpu_cpu_oci_mem_arbiter;
  localparam int AW = 8;
  logic clk = 1'b0, reset_n = 1'b0;
  logic [37:0] jdo = '0;
  logic ta_a = 1'b0, tn_a = 1'b0, ta_b = 1'b0;
  logic [31:0] MonDReg, ram_wdata, ram_rdata;
  logic jtag_busy, jtag_overrun, ram_we;
  logic [AW-1:0] ram_addr;
  logic [3:0] ram_be;
  logic [31:0] mem [256];
  int checks = 0, errors = 0;
  testbench_ls_nios_cpu_cpu_oci_mem_arbiter_if #(.ADDR_W(AW)) cpu_if ();
  testbench_ls_nios_cpu_cpu_oci_mem_arbiter #(.ADDR_W(AW)) dut (
    .clk(clk), .reset_n(reset_n), .jdo(jdo),
    .take_action_ocimem_a(ta_a), .take_no_action_ocimem_a(tn_a), .take_action_ocimem_b(ta_b),
    .MonDReg(MonDReg), .jtag_busy(jtag_busy), .jtag_overrun(jtag_overrun),
    .cpu(cpu_if.slave),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_be(ram_be), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (ram_we) for (int i = 0; i < 4; i++) if (ram_be[i]) mem[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
    ram_rdata <= mem[ram_addr];
  end
  task automatic step; @(posedge clk); #1; endtask
  task automatic mid; @(negedge clk); endtask
  task automatic test_reset;
    reset_n = 1'b0;
    repeat (2) step;
    mid;
    checks++; if (MonDReg !== 32'h0) begin errors++; $display("FAIL rst_mondreg: got %h want 0", MonDReg); end
    checks++; if (jtag_busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", jtag_busy); end
    checks++; if (jtag_overrun !== 1'b0) begin errors++; $display("FAIL rst_overrun: got %b want 0", jtag_overrun); end
    checks++; if (cpu_if.cpu_readdata !== 32'h0) begin errors++; $display("FAIL rst_readdata: got %h want 0", cpu_if.cpu_readdata); end
    checks++; if (cpu_if.cpu_waitrequest !== 1'b0) begin errors++; $display("FAIL rst_waitreq: got %b want 0", cpu_if.cpu_waitrequest); end
    checks++; if ({ram_we, ram_be, ram_addr, ram_wdata} !== '0) begin errors++; $display("FAIL rst_ram: got we=%b be=%h a=%h d=%h want all 0", ram_we, ram_be, ram_addr, ram_wdata); end
    step;
    reset_n = 1'b1;
  endtask
  task automatic test_jtag_read;
    step; jdo = '0; jdo[35] = 1'b1; jdo[33:26] = 8'h10; ta_a = 1'b1; mid;
    checks++; if (jtag_busy !== 1'b0) begin errors++; $display("FAIL jrd_busy_n: got %b want 0", jtag_busy); end
    step; ta_a = 1'b0; mid;
    checks++; if (jtag_busy !== 1'b1) begin errors++; $display("FAIL jrd_busy_n1: got %b want 1", jtag_busy); end
    checks++; if (ram_addr !== 8'h10) begin errors++; $display("FAIL jrd_addr: got %h want 10", ram_addr); end
    step; mid; step; mid;
    checks++; if (MonDReg !== 32'hDEADBEEF) begin errors++; $display("FAIL jrd_data: got %h want deadbeef", MonDReg); end
    checks++; if (jtag_busy !== 1'b0) begin errors++; $display("FAIL jrd_busy_n3: got %b want 0", jtag_busy); end
    step; tn_a = 1'b1; mid; step; tn_a = 1'b0; mid;
    checks++; if (ram_addr !== 8'h11) begin errors++; $display("FAIL jrd_incr: got %h want 11", ram_addr); end
    step; step; mid;
    checks++; if (MonDReg !== 32'h0BADF00D) begin errors++; $display("FAIL jrd_next: got %h want 0badf00d", MonDReg); end
  endtask
  task automatic test_wrap;
    step; jdo = '0; jdo[33:26] = 8'hFF; ta_a = 1'b1; mid;
    step; ta_a = 1'b0; mid;
    checks++; if (jtag_busy !== 1'b0) begin errors++; $display("FAIL wrap_noread: got %b want 0", jtag_busy); end
    step; jdo = '0; jdo[34:3] = 32'h12345678; ta_b = 1'b1; mid;
    step; ta_b = 1'b0; mid;
    checks++; if ({ram_we, ram_be, ram_addr, ram_wdata} !== {1'b1, 4'hF, 8'hFF, 32'h12345678}) begin errors++; $display("FAIL wrap_wr: got we=%b be=%h a=%h d=%h want 1 f ff 12345678", ram_we, ram_be, ram_addr, ram_wdata); end
    step; mid;
    checks++; if (jtag_busy !== 1'b0) begin errors++; $display("FAIL wrap_wrdone: got %b want 0", jtag_busy); end
    checks++; if (mem[255] !== 32'h12345678) begin errors++; $display("FAIL wrap_mem: got %h want 12345678", mem[255]); end
    step; tn_a = 1'b1; mid; step; tn_a = 1'b0; mid;
    checks++; if (ram_addr !== 8'h00) begin errors++; $display("FAIL wrap_addr: got %h want 00", ram_addr); end
    step; step; mid;
    checks++; if (MonDReg !== 32'hCAFE0000) begin errors++; $display("FAIL wrap_data: got %h want cafe0000", MonDReg); end
  endtask
  task automatic test_cpu;
    step; cpu_if.cpu_write = 1'b1; cpu_if.cpu_address = 8'h05; cpu_if.cpu_byteenable = 4'b0011; cpu_if.cpu_writedata = 32'hAABBCCDD; mid;
    checks++; if ({cpu_if.cpu_waitrequest, ram_we, ram_be, ram_addr} !== {1'b0, 1'b1, 4'b0011, 8'h05}) begin errors++; $display("FAIL cpu_wr: got wr=%b we=%b be=%h a=%h want 0 1 3 05", cpu_if.cpu_waitrequest, ram_we, ram_be, ram_addr); end
    step; cpu_if.cpu_write = 1'b0; cpu_if.cpu_read = 1'b1; mid;
    checks++; if ({cpu_if.cpu_waitrequest, ram_we} !== 2'b10) begin errors++; $display("FAIL cpu_rd1: got wr=%b we=%b want 1 0", cpu_if.cpu_waitrequest, ram_we); end
    step; mid;
    checks++; if (cpu_if.cpu_waitrequest !== 1'b0) begin errors++; $display("FAIL cpu_rd2_wait: got %b want 0", cpu_if.cpu_waitrequest); end
    checks++; if (cpu_if.cpu_readdata !== 32'h1122CCDD) begin errors++; $display("FAIL cpu_rd2_data: got %h want 1122ccdd", cpu_if.cpu_readdata); end
    step; cpu_if.cpu_read = 1'b0; mid;
    checks++; if (cpu_if.cpu_waitrequest !== 1'b0) begin errors++; $display("FAIL cpu_idle_wait: got %b want 0", cpu_if.cpu_waitrequest); end
  endtask
  task automatic test_contention;
    step; tn_a = 1'b1; mid;
    step; tn_a = 1'b0; cpu_if.cpu_read = 1'b1; cpu_if.cpu_address = 8'h07; mid;
    checks++; if ({ram_addr, cpu_if.cpu_waitrequest} !== {8'h01, 1'b1}) begin errors++; $display("FAIL tie1_jtag: got a=%h wr=%b want 01 1", ram_addr, cpu_if.cpu_waitrequest); end
    step; mid;
    checks++; if (cpu_if.cpu_waitrequest !== 1'b1) begin errors++; $display("FAIL tie1_jrd_wait: got %b want 1", cpu_if.cpu_waitrequest); end
    step; mid;
    checks++; if ({ram_addr, cpu_if.cpu_waitrequest} !== {8'h07, 1'b1}) begin errors++; $display("FAIL tie1_cpu: got a=%h wr=%b want 07 1", ram_addr, cpu_if.cpu_waitrequest); end
    checks++; if (MonDReg !== 32'h01010101) begin errors++; $display("FAIL tie1_mon: got %h want 01010101", MonDReg); end
    step; tn_a = 1'b1; mid;
    checks++; if ({cpu_if.cpu_waitrequest, cpu_if.cpu_readdata} !== {1'b0, 32'h07070707}) begin errors++; $display("FAIL tie1_cpu_done: got wr=%b d=%h want 0 07070707", cpu_if.cpu_waitrequest, cpu_if.cpu_readdata); end
    step; tn_a = 1'b0; cpu_if.cpu_address = 8'h08; mid;
    checks++; if (ram_addr !== 8'h02) begin errors++; $display("FAIL tie2_jtag: got %h want 02", ram_addr); end
    step; mid; step; mid;
    checks++; if (ram_addr !== 8'h08) begin errors++; $display("FAIL tie2_cpu: got %h want 08", ram_addr); end
    step; mid;
    checks++; if (cpu_if.cpu_readdata !== 32'h08080808) begin errors++; $display("FAIL tie2_data: got %h want 08080808", cpu_if.cpu_readdata); end
    step; cpu_if.cpu_read = 1'b0; jdo = '0; jdo[34:3] = 32'h33333333; ta_b = 1'b1; mid;
    step; ta_b = 1'b0; mid;
    checks++; if ({ram_we, ram_addr} !== {1'b1, 8'h03}) begin errors++; $display("FAIL rr_jwr: got we=%b a=%h want 1 03", ram_we, ram_addr); end
    step; tn_a = 1'b1; mid;
    step; tn_a = 1'b0; cpu_if.cpu_read = 1'b1; cpu_if.cpu_address = 8'h09; mid;
    checks++; if (ram_addr !== 8'h09) begin errors++; $display("FAIL rr_cpu_wins: got %h want 09", ram_addr); end
    step; mid;
    checks++; if (cpu_if.cpu_readdata !== 32'h09090909) begin errors++; $display("FAIL rr_cpu_data: got %h want 09090909", cpu_if.cpu_readdata); end
    step; cpu_if.cpu_read = 1'b0; mid;
    checks++; if (ram_addr !== 8'h04) begin errors++; $display("FAIL rr_jtag_next: got %h want 04", ram_addr); end
    step; step; mid;
    checks++; if (MonDReg !== 32'h04040404) begin errors++; $display("FAIL rr_jtag_data: got %h want 04040404", MonDReg); end
  endtask
  task automatic test_overrun;
    step; jdo = '0; jdo[34:3] = 32'hA5A5A5A5; ta_b = 1'b1; mid;
    step; jdo[34:3] = 32'h5A5A5A5A; mid;
    checks++; if ({ram_addr, ram_wdata} !== {8'h05, 32'hA5A5A5A5}) begin errors++; $display("FAIL ovr_wr: got a=%h d=%h want 05 a5a5a5a5", ram_addr, ram_wdata); end
    step; ta_b = 1'b0; mid;
    checks++; if ({jtag_busy, jtag_overrun} !== 2'b01) begin errors++; $display("FAIL ovr_drop: got busy=%b ovr=%b want 0 1", jtag_busy, jtag_overrun); end
    repeat (3) step;
    mid;
    checks++; if (jtag_overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky: got %b want 1", jtag_overrun); end
  endtask
  task automatic test_reset_mid;
    step; jdo = '0; jdo[35] = 1'b1; jdo[33:26] = 8'h20; ta_a = 1'b1; mid;
    step; ta_a = 1'b0; mid; step; mid;
    checks++; if (jtag_busy !== 1'b1) begin errors++; $display("FAIL rmid_busy: got %b want 1", jtag_busy); end
    #1 reset_n = 1'b0; cpu_if.cpu_write = 1'b1; cpu_if.cpu_address = 8'h30; cpu_if.cpu_byteenable = 4'hF;
    #1;
    checks++; if ({MonDReg, jtag_busy, jtag_overrun, ram_we} !== '0) begin errors++; $display("FAIL rmid_clear: got mon=%h busy=%b ovr=%b we=%b want 0", MonDReg, jtag_busy, jtag_overrun, ram_we); end
    step; reset_n = 1'b1; cpu_if.cpu_write = 1'b0; cpu_if.cpu_read = 1'b1; mid;
    checks++; if ({ram_addr, jtag_busy} !== {8'h30, 1'b0}) begin errors++; $display("FAIL rmid_idle: got a=%h busy=%b want 30 0", ram_addr, jtag_busy); end
    step; mid;
    checks++; if ({cpu_if.cpu_readdata, MonDReg} !== {32'h30303030, 32'h0}) begin errors++; $display("FAIL rmid_after: got d=%h mon=%h want 30303030 0", cpu_if.cpu_readdata, MonDReg); end
    step; cpu_if.cpu_read = 1'b0;
  endtask
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = {4{8'(i)}};
    mem[8'h00] = 32'hCAFE0000;
    mem[8'h05] = 32'h11223344;
    mem[8'h10] = 32'hDEADBEEF;
    mem[8'h11] = 32'h0BADF00D;
    cpu_if.cpu_read = 1'b0; cpu_if.cpu_write = 1'b0; cpu_if.cpu_address = '0;
    cpu_if.cpu_writedata = '0; cpu_if.cpu_byteenable = '0;
    test_reset;
    test_jtag_read;
    test_wrap;
    test_cpu;
    test_contention;
    test_overrun;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
